// File: rtl/register_file_scoreboard.sv
// RISC-V integer register file: two combinational read ports, one synchronous write port,
// optional write->read forwarding and a per-register busy scoreboard for hazard stalls.
module register_file_scoreboard #(
  parameter int  N        = 32,
  parameter int  NUM_REGS = 32,
  localparam int ADDR_W   = $clog2(NUM_REGS),
  parameter bit  BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_ena,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]      wr_data,
  input  logic              rsv_ena,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr0,
  output logic [N-1:0]      rd_data0,
  output logic              rd_busy0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [N-1:0]      rd_data1,
  output logic              rd_busy1,
  output logic [ADDR_W:0]   pending
);

  // Interface contract: no valid/ready handshake. Strobes are acted on at every
  // rising edge they are high; the core stalls itself on rd_busy0 | rd_busy1.

  logic [N-1:0]        regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [ADDR_W:0]     pending_next;
  logic                wr_live;
  logic                rsv_live;

  assign wr_live  = wr_ena && (wr_addr != '0);
  assign rsv_live = rsv_ena && (rsv_addr != '0);

  // Entry 0 is reset and never written, so it folds away to a constant zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Clear-on-write first, then reserve, so a same-cycle reserve keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (wr_live)  busy_next[wr_addr]  = 1'b0;
    if (rsv_live) busy_next[rsv_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    pending_next = '0;
    for (int i = 1; i < NUM_REGS; i++) pending_next = pending_next + (ADDR_W+1)'(busy_next[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= '0;
      pending <= '0;
    end else begin
      busy    <= busy_next;
      pending <= pending_next;
    end
  end

  function automatic logic fwd_hit(input logic [ADDR_W-1:0] addr);
    return BYPASS && wr_ena && (wr_addr == addr);
  endfunction

  function automatic logic [N-1:0] read_data(input logic [ADDR_W-1:0] addr);
    if (addr == '0)    return '0;
    if (fwd_hit(addr)) return wr_data;
    return regs[addr];
  endfunction

  // A forwarded value is not a hazard unless a new writer reserves the same register now.
  function automatic logic read_busy(input logic [ADDR_W-1:0] addr);
    if (fwd_hit(addr) && !(rsv_ena && (rsv_addr == addr))) return 1'b0;
    return busy[addr];
  endfunction

  always_comb begin
    rd_data0 = read_data(rd_addr0);
    rd_data1 = read_data(rd_addr1);
    rd_busy0 = read_busy(rd_addr0);
    rd_busy1 = read_busy(rd_addr1);
  end

endmodule
